// File: rtl/serial_subtractor_bf.sv
// Bit-serial N-bit unsigned subtractor, d = a - b, LSB first, one bit per clock.
// A registered borrow flop carries between bit steps behind a start/busy/done handshake.
module serial_subtractor_bf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          finish;

    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic [N-1:0]  rr;
    logic          br;
    logic [CW-1:0] count;

    logic          diff_bit;
    logic          br_next;
    logic [N-1:0]  rr_next;

    assign diff_bit = ra[0] ^ rb[0] ^ br;
    assign br_next  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    assign rr_next  = {diff_bit, rr[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // d/bout only move at completion, so a reader never sees a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            rr    <= '0;
            br    <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                ra    <= a;
                rb    <= b;
                br    <= 1'b0;
                count <= '0;
                busy  <= 1'b1;
            end else if (state == SHIFT) begin
                ra    <= {1'b0, ra[N-1:1]};
                rb    <= {1'b0, rb[N-1:1]};
                rr    <= rr_next;
                br    <= br_next;
                count <= count + 1'b1;
                if (finish) begin
                    d    <= rr_next;
                    bout <= br_next;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_bf.sv
// Randomized and exhaustive bench for serial_subtractor_bf at N=4 and N=8,
// scored against a plain-arithmetic model of a - b and the N-edge completion latency.
module tb_serial_subtractor_bf;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4, d4;
    logic [7:0] a8, b8, d8;
    logic       busy4, done4, bout4;
    logic       busy8, done8, bout8;

    int total = 0;
    int bad   = 0;

    logic        sel;
    logic        busy_s, done_s, bout_s;
    logic [31:0] d_s;
    logic [31:0] last4, last8;

    always #5 clk = ~clk;

    serial_subtractor_bf #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
    );

    serial_subtractor_bf #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    always_comb begin
        busy_s = sel ? busy8 : busy4;
        done_s = sel ? done8 : done4;
        bout_s = sel ? bout8 : bout4;
        d_s    = sel ? 32'(d8) : 32'(d4);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {bout,d} read as an N+1-bit two's complement number is exactly a - b.
    function automatic logic [31:0] ref_sub(input int n, input int av, input int bv);
        int diff;
        diff = av - bv;
        return 32'(diff) & ((32'd1 << (n + 1)) - 32'd1);
    endfunction

    task automatic run_op(input bit wide, input int av, input int bv);
        int n;
        int k;
        logic [31:0] exp;
        logic [31:0] prev;
        n    = wide ? 8 : 4;
        sel  = wide;
        prev = wide ? last8 : last4;
        @(posedge clk); #1;
        if (wide) begin a8 = 8'(av); b8 = 8'(bv); start8 = 1'b1; end
        else      begin a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1; end
        @(posedge clk); #1;
        start4 = 1'b0;
        start8 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        chk("done_after_accept", 32'(done_s), 32'd0);
        k = 0;
        while (!done_s && k < 3 * n) begin
            chk("busy_in_shift", 32'(busy_s), 32'd1);
            chk("d_hold_in_shift", d_s, prev);
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'(n));
        exp = ref_sub(n, av, bv);
        chk("result", (32'(bout_s) << n) | d_s, exp);
        chk("busy_at_done", 32'(busy_s), 32'd0);
        if (wide) last8 = exp & ((32'd1 << n) - 32'd1);
        else      last4 = exp & ((32'd1 << n) - 32'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done_s), 32'd0);
        chk("d_after_done", (32'(bout_s) << n) | d_s, exp);
    endtask

    initial begin
        int acc;
        int next_acc;
        int qa;
        int qb;
        logic [31:0] exp;

        rst    = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
        sel   = 1'b0;
        last4 = 32'd0;
        last8 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_d4", 32'(d4), 32'd0);
        chk("rst_bout4", 32'(bout4), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_d8", 32'(d8), 32'd0);
        rst = 1'b0;

        // Directed cases first, including the borrow and all-equal corners.
        run_op(0, 9, 3);
        run_op(0, 3, 9);
        run_op(0, 0, 1);
        run_op(0, 15, 15);
        run_op(0, 0, 0);
        run_op(0, 15, 0);

        // start held high while operands churn every cycle: only accept-edge values count.
        @(posedge clk); #1;
        start4 = 1'b1;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        next_acc = 0;
        acc = -100;
        qa = 0;
        qb = 0;
        for (int e = 0; e < 42; e++) begin
            if (e == next_acc) begin
                qa = int'(a4);
                qb = int'(b4);
                acc = e;
                next_acc = e + 6;
            end
            @(posedge clk); #1;
            chk("cont_done", 32'(done4), 32'(e == acc + 4));
            if (e == acc + 4) begin
                exp = ref_sub(4, qa, qb);
                chk("cont_result", (32'(bout4) << 4) | 32'(d4), exp);
                last4 = exp & 32'hF;
            end else begin
                chk("cont_hold", 32'(d4), last4);
            end
            a4 = 4'($urandom);
            b4 = 4'($urandom);
        end
        start4 = 1'b0;

        // Reset in the 2nd SHIFT cycle aborts the operation and clears the result.
        @(posedge clk); #1;
        a4 = 4'd12; b4 = 4'd5; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_done", 32'(done4), 32'd0);
        chk("abort_d", 32'(d4), 32'd0);
        chk("abort_bout", 32'(bout4), 32'd0);
        last4 = 32'd0;
        last8 = 32'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done4), 32'd0);
        end
        run_op(0, 12, 5);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(0, x, y);
            end
        end

        run_op(1, 0, 255);
        run_op(1, 255, 0);
        run_op(1, 128, 128);
        for (int i = 0; i < 150; i++) begin
            run_op(1, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
